calc_memctl: RTL and testbench

CALC_MEMCTL -- requirements
Module: calc_memctl

---
 rtl/calc_memctl.sv | 180 ++++++++++++++++++
 tb/tb_calc_memctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_memctl.sv
`default_nettype none
// ============================================================================
// Module   : calc_memctl
// Purpose  : Calculator memory controller. Handles store, recall and clear
//            requests. A recall replays the stored BCD value into operand A or
//            B as a clear pulse followed by per-digit load pulses.
// Options  : CALC_MEMCTL_DROPCOUNT_EN - when defined, adds a saturating
//            counter of rejected requests on drop_count. Otherwise drop_count
//            is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module calc_memctl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ms_strobe,
  input  logic        mr_strobe,
  input  logic        mc_strobe,
  input  logic        target_sel,
  input  logic [31:0] result_in,
  output logic [3:0]  dig_code,
  output logic        load_A,
  output logic        load_B,
  output logic        clear_A,
  output logic        clear_B,
  output logic        busy,
  output logic        done,
  output logic        mem_valid,
  output logic [31:0] mem_value,
  output logic        dropped,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_idx;
  logic [31:0] r_snap;
  logic        r_tgt;
  logic        r_loaded;
  logic [31:0] r_mem_value;
  logic        r_mem_valid;
  logic        r_dropped;

  logic        w_busy;
  logic        w_ms_win;
  logic        w_mr_win;
  logic        w_accept;
  logic        w_drop;
  logic        w_load;
  logic [3:0]  w_dig;
  logic [3:0]  w_nib;

  // Request arbitration: clear beats store beats recall; losers are ignored.
  assign w_busy   = (r_state != IDLE);
  assign w_ms_win = ms_strobe & ~mc_strobe;
  assign w_mr_win = mr_strobe & ~mc_strobe & ~ms_strobe;
  assign w_accept = ~w_busy & w_mr_win & r_mem_valid;
  assign w_drop   = w_busy ? (w_ms_win | w_mr_win) : (w_mr_win & ~r_mem_valid);
  assign w_nib    = r_snap[{r_idx, 2'b00} +: 4];

  assign mem_value = r_mem_value;
  assign mem_valid = r_mem_valid;
  assign dropped   = r_dropped;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and replay outputs; leading zeros and non-BCD nibbles produce
  // no load, but a value with no loadable digit still yields a single 0.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    clear_A     = 1'b0;
    clear_B     = 1'b0;
    load_A      = 1'b0;
    load_B      = 1'b0;
    dig_code    = 4'd0;
    w_load      = 1'b0;
    w_dig       = 4'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        busy        = 1'b1;
        clear_A     = ~r_tgt;
        clear_B     = r_tgt;
        w_state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if ((w_nib <= 4'd9) && ((w_nib != 4'd0) || r_loaded)) begin
          w_load = 1'b1;
          w_dig  = w_nib;
        end else if ((r_idx == 3'd0) && !r_loaded) begin
          w_load = 1'b1;
          w_dig  = 4'd0;
        end
        load_A   = w_load & ~r_tgt;
        load_B   = w_load & r_tgt;
        dig_code = w_dig;
        if (r_idx == 3'd0) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Recall context: snapshot on accept, digit index and "digit loaded" flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap   <= 32'd0;
      r_tgt    <= 1'b0;
      r_idx    <= 3'd0;
      r_loaded <= 1'b0;
    end else begin
      if (w_accept) begin
        r_snap <= r_mem_value;
        r_tgt  <= target_sel;
      end
      if (r_state == CLEAR) begin
        r_idx    <= 3'd7;
        r_loaded <= 1'b0;
      end else if (r_state == SCAN) begin
        r_idx <= r_idx - 3'd1;
        if (w_load) r_loaded <= 1'b1;
      end
    end
  end

  // Memory register; clear works in any state, store only when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_value <= 32'd0;
      r_mem_valid <= 1'b0;
    end else if (mc_strobe) begin
      r_mem_value <= 32'd0;
      r_mem_valid <= 1'b0;
    end else if (w_ms_win && !w_busy) begin
      r_mem_value <= result_in;
      r_mem_valid <= 1'b1;
    end
  end

  // Rejected-request pulse, one cycle after the offending strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_dropped <= 1'b0;
    else       r_dropped <= w_drop;
  end

`ifdef CALC_MEMCTL_DROPCOUNT_EN
  logic [7:0] r_drop_count;

  // Saturating reject counter, updated together with the dropped pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            r_drop_count <= 8'd0;
    else if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_memctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_memctl
// Purpose  : Self-checking bench for calc_memctl using a transaction-level
//            reference model (recall phase counter and digit replay list).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_memctl;

`ifdef CALC_MEMCTL_DROPCOUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ms_strobe, mr_strobe, mc_strobe, target_sel;
  logic [31:0] result_in;
  logic [3:0]  dig_code;
  logic        load_A, load_B, clear_A, clear_B, busy, done, mem_valid, dropped;
  logic [31:0] mem_value;
  logic [7:0]  drop_count;

  calc_memctl dut (
    .clock(clock), .reset(reset),
    .ms_strobe(ms_strobe), .mr_strobe(mr_strobe), .mc_strobe(mc_strobe),
    .target_sel(target_sel), .result_in(result_in),
    .dig_code(dig_code), .load_A(load_A), .load_B(load_B),
    .clear_A(clear_A), .clear_B(clear_B), .busy(busy), .done(done),
    .mem_valid(mem_valid), .mem_value(mem_value),
    .dropped(dropped), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem;
  logic        m_valid;
  int          m_phase;     // 0 idle, 1 clear, 2..9 digits 7..0, 10 done
  logic        m_tgt;
  logic        m_drop;
  int          m_dcnt;
  logic [3:0]  m_dig [8];
  logic        m_ld  [8];

  // Observation of DUT load activity for directed checks
  int          obs_n;
  logic [31:0] obs_pack;
  int          obs_busy;
  int          obs_b;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Replay rule: skip non-BCD nibbles, suppress leading zeros, and emit a
  // single 0 if nothing else was loaded by the last digit.
  task automatic build_replay(input logic [31:0] v);
    bit seen = 0;
    for (int i = 7; i >= 0; i--) begin
      logic [3:0] nib = v[i*4 +: 4];
      m_ld[i]  = 1'b0;
      m_dig[i] = 4'd0;
      if (nib <= 9 && (nib != 0 || seen)) begin
        m_ld[i] = 1'b1; m_dig[i] = nib; seen = 1;
      end else if (i == 0 && !seen) begin
        m_ld[i] = 1'b1; m_dig[i] = 4'd0;
      end
    end
  endtask

  task automatic model_reset();
    m_mem = 0; m_valid = 0; m_phase = 0; m_tgt = 0; m_drop = 0; m_dcnt = 0;
  endtask

  task automatic model_edge(input logic ms, mr, mc, ts, input logic [31:0] res);
    int nxt;
    nxt = (m_phase == 0 || m_phase == 10) ? 0 : m_phase + 1;
    m_drop = 1'b0;
    if (mc) begin
      m_mem = 0; m_valid = 0;
    end else if (ms) begin
      if (m_phase == 0) begin m_mem = res; m_valid = 1; end
      else m_drop = 1;
    end else if (mr) begin
      if (m_phase == 0 && m_valid) begin
        build_replay(m_mem); m_tgt = ts; nxt = 1;
      end else m_drop = 1;
    end
    if (m_drop && DC_EN && m_dcnt < 255) m_dcnt++;
    m_phase = nxt;
  endtask

  task automatic check_outputs();
    logic ld;
    logic [3:0] dg;
    ld = 0; dg = 0;
    if (m_phase >= 2 && m_phase <= 9) begin
      ld = m_ld[9 - m_phase];
      dg = ld ? m_dig[9 - m_phase] : 4'd0;
    end
    check_val("busy",       busy,       m_phase != 0);
    check_val("done",       done,       m_phase == 10);
    check_val("clear_A",    clear_A,    m_phase == 1 && !m_tgt);
    check_val("clear_B",    clear_B,    m_phase == 1 && m_tgt);
    check_val("load_A",     load_A,     ld && !m_tgt);
    check_val("load_B",     load_B,     ld && m_tgt);
    check_val("dig_code",   dig_code,   dg);
    check_val("mem_valid",  mem_valid,  m_valid);
    check_val("mem_value",  mem_value,  m_mem);
    check_val("dropped",    dropped,    m_drop);
    check_val("drop_count", drop_count, m_dcnt);
    if (load_A || load_B) begin
      obs_pack = {obs_pack[27:0], dig_code};
      obs_n++;
    end
    if (load_B) obs_b++;
    if (busy) obs_busy++;
  endtask

  task automatic obs_clear();
    obs_n = 0; obs_pack = 0; obs_busy = 0; obs_b = 0;
  endtask

  // One clock cycle: drive at negedge, model the rising edge, check at negedge.
  task automatic cyc(input logic ms, mr, mc, ts, input logic [31:0] res);
    ms_strobe = ms; mr_strobe = mr; mc_strobe = mc; target_sel = ts; result_in = res;
    @(posedge clock);
    model_edge(ms, mr, mc, ts, res);
    @(negedge clock);
    ms_strobe = 0; mr_strobe = 0; mc_strobe = 0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd0);
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    int r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      v[i*4 +: 4] = 4'd0;
      else if (r < 8) v[i*4 +: 4] = 4'($urandom_range(1, 9));
      else            v[i*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    reset = 1; ms_strobe = 0; mr_strobe = 0; mc_strobe = 0; target_sel = 0; result_in = 0;
    model_reset();
    obs_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs();
    reset = 0;

    // Store 0x123, recall into A
    cyc(1, 0, 0, 0, 32'h0000_0123);
    obs_clear();
    cyc(0, 1, 0, 0, 32'd0);
    idle(10);
    check_val("r033_nloads", obs_n, 3);
    check_val("r033_digits", obs_pack, 32'h123);
    check_val("r033_busy",   obs_busy, 10);

    // Recall with empty memory is rejected
    cyc(0, 0, 1, 0, 32'd0);
    obs_clear();
    cyc(0, 1, 0, 0, 32'd0);
    idle(2);
    check_val("r034_busy", obs_busy, 0);
    check_val("r034_dcnt", drop_count, DC_EN ? 1 : 0);

    // Stored zero recalls as a single 0 into B
    cyc(1, 0, 0, 0, 32'd0);
    obs_clear();
    cyc(0, 1, 0, 1, 32'd0);
    idle(10);
    check_val("r035_nloads", obs_n, 1);
    check_val("r035_loadB",  obs_b, 1);
    check_val("r035_digits", obs_pack, 32'h0);

    // Non-BCD nibble skipped, inner zero kept
    cyc(1, 0, 0, 0, 32'h0F00_0405);
    obs_clear();
    cyc(0, 1, 0, 0, 32'd0);
    idle(10);
    check_val("r036_nloads", obs_n, 3);
    check_val("r036_digits", obs_pack, 32'h405);

    // All three strobes together: clear wins, nothing else happens
    cyc(1, 0, 0, 0, 32'h0000_0055);
    obs_clear();
    cyc(1, 1, 1, 1, 32'h0000_0077);
    idle(3);
    check_val("r037_busy",  obs_busy, 0);
    check_val("r037_valid", mem_valid, 0);

    // Clear during a recall: memory empties, replay unaffected
    cyc(1, 0, 0, 0, 32'h9876_5432);
    obs_clear();
    cyc(0, 1, 0, 1, 32'd0);
    idle(3);
    cyc(0, 0, 1, 0, 32'd0);
    idle(8);
    check_val("r037_nloads", obs_n, 8);
    check_val("r037_digits", obs_pack, 32'h9876_5432);

    // Reset in the middle of SCAN
    cyc(1, 0, 0, 0, 32'h1234_5678);
    cyc(0, 1, 0, 0, 32'd0);
    idle(4);
    #2 reset = 1;
    #1 model_reset();
    obs_clear();
    check_outputs();
    @(posedge clock);
    @(negedge clock);
    check_outputs();
    reset = 0;
    idle(12);
    check_val("r038_noload", obs_n, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic ms, mr, mc;
      mc = ($urandom_range(0, 24) == 0);
      ms = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 4) == 0);
      cyc(ms, mr, mc, 1'($urandom_range(0, 1)), rand_bcd());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
